// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational 32-bit ALU between two requesters.
// Define ALU_ARB_PERF_EN to add saturating grant/conflict performance counters.

module alu (
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic signed [31:0] sa;
    logic signed [31:0] sb;

    assign sa = a;
    assign sb = b;

    always_comb begin
        y = '0;
        case (op)
            4'b0000: y = a + b;
            4'b0001: y = a - b;
            4'b0010: y = a & b;
            4'b0011: y = a | b;
            4'b0100: y = a ^ b;
            4'b0101: y = a << b[4:0];
            4'b0110: y = a >> b[4:0];
            4'b0111: y = $unsigned(sa >>> b[4:0]);
            4'b1000: y = {31'b0, sa < sb};
            4'b1001: y = {31'b0, a < b};
            // Undefined opcodes fall through to a logical right shift.
            default: y = a >> b[4:0];
        endcase
    end
endmodule

module alu_share_arbiter #(
    parameter int unsigned PRIO_RESET = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [3:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [31:0]      rsp0_data,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp1_data,
    output logic             rsp1_err
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_grant0,
    output logic [CNT_W-1:0] perf_grant1,
    output logic [CNT_W-1:0] perf_conflict
`endif
);
    typedef enum logic {IDLE, RESP} state_t;

    state_t      state;
    logic        rr_ptr;
    logic        gnt_any;
    logic        gnt_sel;
    logic [3:0]  op_mux;
    logic [31:0] a_mux;
    logic [31:0] b_mux;
    logic [31:0] b_cond;
    logic [31:0] alu_y;
    logic        op_illegal;

    always_comb begin
        gnt_any = (state == IDLE) && (req0_valid || req1_valid);
        gnt_sel = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    end

    assign req0_ready = gnt_any && !gnt_sel;
    assign req1_ready = gnt_any &&  gnt_sel;

    assign op_mux = gnt_sel ? req1_op : req0_op;
    assign a_mux  = gnt_sel ? req1_a  : req0_a;
    assign b_mux  = gnt_sel ? req1_b  : req0_b;

    // Shifts only see the RV32I 5-bit shift amount; illegal ops keep b untouched.
    assign b_cond = (op_mux == 4'b0101 || op_mux == 4'b0110 || op_mux == 4'b0111)
                    ? {27'b0, b_mux[4:0]} : b_mux;
    assign op_illegal = (op_mux > 4'b1001);

    alu u_alu (
        .op (op_mux),
        .a  (a_mux),
        .b  (b_cond),
        .y  (alu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= 1'(PRIO_RESET);
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_data  <= '0;
            rsp0_err   <= 1'b0;
            rsp1_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        if (gnt_sel) begin
                            rsp1_data  <= alu_y;
                            rsp1_err   <= op_illegal;
                            rsp1_valid <= 1'b1;
                        end else begin
                            rsp0_data  <= alu_y;
                            rsp0_err   <= op_illegal;
                            rsp0_valid <= 1'b1;
                        end
                        rr_ptr <= ~gnt_sel;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    // Only the granted port is valid, so either handshake ends the op.
                    if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_PERF_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_grant0   <= '0;
            perf_grant1   <= '0;
            perf_conflict <= '0;
        end else begin
            if (req0_valid && req0_ready) perf_grant0 <= sat_inc(perf_grant0);
            if (req1_valid && req1_ready) perf_grant1 <= sat_inc(perf_grant1);
            if (state == IDLE && req0_valid && req1_valid)
                perf_conflict <= sat_inc(perf_conflict);
        end
    end
`else
    // CNT_W only sizes the counters; keep it referenced when they are absent.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter (default PRIO_RESET = 0).
// Counter checks are included when ALU_ARB_PERF_EN is defined.

module tb_alu_share_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp0_ready, rsp0_err;
    logic        rsp1_valid, rsp1_ready, rsp1_err;
    logic [31:0] rsp0_data, rsp1_data;
`ifdef ALU_ARB_PERF_EN
    logic [15:0] perf_grant0, perf_grant1, perf_conflict;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp0_err   (rsp0_err),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .rsp1_err   (rsp1_err)
`ifdef ALU_ARB_PERF_EN
        ,
        .perf_grant0   (perf_grant0),
        .perf_grant1   (perf_grant1),
        .perf_conflict (perf_conflict)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        rsp0_ready = 0; rsp1_ready = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        step(); step();
        rst_n = 1'b1;
    endtask

    // One full transaction on a port with bounded wait for the grant.
    task automatic do_op(input string tag, input bit port, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input logic exp_err);
        logic rdy;
        if (port) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
        else      begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
        #1;
        rdy = port ? req1_ready : req0_ready;
        for (int i = 0; i < 10 && !rdy; i++) begin
            step();
            rdy = port ? req1_ready : req0_ready;
        end
        check({tag, "_ready"}, 32'(rdy), 32'd1);
        step();
        req0_valid = 0; req1_valid = 0;
        check({tag, "_valid"}, 32'(port ? rsp1_valid : rsp0_valid), 32'd1);
        check({tag, "_other_valid"}, 32'(port ? rsp0_valid : rsp1_valid), 32'd0);
        check({tag, "_data"}, port ? rsp1_data : rsp0_data, exp);
        check({tag, "_err"}, 32'(port ? rsp1_err : rsp0_err), 32'(exp_err));
        if (port) rsp1_ready = 1; else rsp0_ready = 1;
        step();
        rsp0_ready = 0; rsp1_ready = 0;
        check({tag, "_consumed"}, 32'(port ? rsp1_valid : rsp0_valid), 32'd0);
    endtask

    initial begin
        do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        check("rst_rsp0_data", rsp0_data, 32'd0);
        check("rst_rsp1_data", rsp1_data, 32'd0);
        check("rst_errs", 32'({rsp0_err, rsp1_err}), 32'd0);
        step();
        rst_n = 1'b1;

        // Solo request straight after reset release.
        do_op("solo_add", 1'b0, 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0);
        check("retain_rsp0_data", rsp0_data, 32'd12);

        // Simultaneous requests, port 0 holds priority after reset.
        do_reset();
        req0_valid = 1; req0_op = 4'b0001; req0_a = 32'd10;  req0_b = 32'd3;
        req1_valid = 1; req1_op = 4'b0100; req1_a = 32'hF0; req1_b = 32'h0F;
        #1;
        check("both_req0_ready", 32'(req0_ready), 32'd1);
        check("both_req1_ready", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 0;
        check("both_rsp0_data", rsp0_data, 32'd7);
        check("both_rsp1_idle", 32'(rsp1_valid), 32'd0);
        check("both_resp_req1_ready", 32'(req1_ready), 32'd0);
        rsp0_ready = 1;
        step();
        rsp0_ready = 0;
        check("both_req1_granted", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 0;
        check("both_rsp1_valid", 32'(rsp1_valid), 32'd1);
        check("both_rsp1_data", rsp1_data, 32'hFF);
        rsp1_ready = 1;
        step();
        rsp1_ready = 0;
        req0_valid = 1; req1_valid = 1;
        #1;
        check("rr_back_to_0", 32'({req1_ready, req0_ready}), 32'b01);
        req0_valid = 0; req1_valid = 0;

        // Shift amount conditioning and compare ops.
        do_op("sll", 1'b1, 4'b0101, 32'd1, 32'h23, 32'h8, 1'b0);
        do_op("sra", 1'b1, 4'b0111, 32'h8000_0000, 32'h21, 32'hC000_0000, 1'b0);
        do_op("srl", 1'b0, 4'b0110, 32'h8000_0000, 32'h3F, 32'h1, 1'b0);
        do_op("slt", 1'b0, 4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        do_op("sltu", 1'b1, 4'b1001, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);

        // Backpressure on port 0 while port 1 waits.
        req0_valid = 1; req0_op = 4'b0010; req0_a = 32'h6; req0_b = 32'h3;
        step();
        req0_valid = 0;
        req1_valid = 1; req1_op = 4'b0011; req1_a = 32'hA0; req1_b = 32'h0B;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp0_valid", 32'(rsp0_valid), 32'd1);
            check("bp_rsp0_data", rsp0_data, 32'h2);
            check("bp_req1_ready", 32'(req1_ready), 32'd0);
            step();
        end
        rsp0_ready = 1;
        step();
        rsp0_ready = 0;
        check("bp_req1_granted", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 0;
        check("bp_rsp1_data", rsp1_data, 32'hAB);
        rsp1_ready = 1;
        step();
        rsp1_ready = 0;

        // Illegal opcode still executes and flags an error.
        do_op("illegal", 1'b0, 4'b1100, 32'h100, 32'd4, 32'h10, 1'b1);
        do_op("legal_after", 1'b0, 4'b0000, 32'd1, 32'd1, 32'd2, 1'b0);

        // Reset while a response is pending on port 1.
        req1_valid = 1; req1_op = 4'b0000; req1_a = 32'd1; req1_b = 32'd2;
        step();
        req1_valid = 0;
        check("mid_rsp1_valid", 32'(rsp1_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        check("mid_rst_rsp1_data", rsp1_data, 32'd0);
`ifdef ALU_ARB_PERF_EN
        check("perf_grant0", 32'(perf_grant0), 32'd0);
        check("perf_grant1", 32'(perf_grant1), 32'd0);
        check("perf_conflict", 32'(perf_conflict), 32'd0);
`endif
        step();
        rst_n = 1'b1;
        step(); step();
        check("post_rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("post_rst_rsp1_valid", 32'(rsp1_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
